// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory write path: loader states,
// memory geometry and the word-count width helper.
package imem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        WRITE,
        DONE,
        ERR
    } loader_state_t;

    localparam int IMEM_SIZE  = 1024;
    localparam int IMEM_WORDS = IMEM_SIZE / 4;

    // One extra bit so a count equal to the full memory size is representable.
    function automatic int cnt_width(input int mem_size);
        return $clog2(mem_size / 4) + 1;
    endfunction

    localparam int CNT_W = cnt_width(IMEM_SIZE);

endpackage

// File: rtl/imem_loader_if.sv
// Control, byte-stream and memory write-port signals of the program loader.
// The host drives through master; the loader sits on slave.
interface imem_loader_if #(
    parameter int CNT_W = imem_pkg::CNT_W
);

    logic             start;
    logic [CNT_W-1:0] word_count;
    logic             byte_valid;
    logic [7:0]       byte_data;
    logic             byte_ready;
    logic             wr_en;
    logic [63:0]      wr_addr;
    logic [31:0]      wr_data;
    logic             busy;
    logic             done;
    logic             error;
    logic             core_hold;

    modport master (
        output start, word_count, byte_valid, byte_data,
        input  byte_ready, wr_en, wr_addr, wr_data, busy, done, error, core_hold
    );

    modport slave (
        input  start, word_count, byte_valid, byte_data,
        output byte_ready, wr_en, wr_addr, wr_data, busy, done, error, core_hold
    );

endinterface

// File: rtl/byte_packer.sv
// Packs accepted bytes into a little-endian 32-bit word, lane 0 first.
module byte_packer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        accept,
    input  logic        clear,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        last_byte
);

    logic [1:0] lane;

    assign last_byte = accept && (lane == 2'd3);

    // Lane index wraps after the fourth byte, so the next word starts at lane 0 on its own.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lane <= '0;
            word <= '0;
        end else if (clear) begin
            lane <= '0;
            word <= '0;
        end else if (accept) begin
            word[{lane, 3'b000} +: 8] <= byte_data;
            lane                      <= lane + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Streams a program into the instruction memory word by word and keeps the
// core in reset until the whole program has landed.
module imem_loader
    import imem_pkg::*;
#(
    parameter int MEM_SIZE = IMEM_SIZE,
    parameter int CNT_W    = cnt_width(MEM_SIZE)
) (
    input logic          clk,
    input logic          reset_n,
    imem_loader_if.slave bus
);

    localparam logic [CNT_W-1:0] MAX_WORDS = CNT_W'(MEM_SIZE / 4);

    loader_state_t    state;
    loader_state_t    next_state;
    logic [CNT_W-1:0] words_left;
    logic [63:0]      addr;
    logic             start_ok;
    logic             accept;
    logic             last_byte;
    logic [31:0]      word;

    assign accept = (state == RECV) && bus.byte_valid;

    byte_packer u_packer (
        .clk       (clk),
        .reset_n   (reset_n),
        .accept    (accept),
        .clear     (start_ok),
        .byte_data (bus.byte_data),
        .word      (word),
        .last_byte (last_byte)
    );

    // Counts are checked up front, so a started load can never run past the memory.
    always_comb begin
        next_state = state;
        start_ok   = 1'b0;
        case (state)
            IDLE, DONE, ERR: begin
                if (bus.start) begin
                    if (bus.word_count == '0) begin
                        next_state = DONE;
                    end else if (bus.word_count > MAX_WORDS) begin
                        next_state = ERR;
                    end else begin
                        next_state = RECV;
                        start_ok   = 1'b1;
                    end
                end
            end
            RECV: begin
                if (last_byte) begin
                    next_state = WRITE;
                end
            end
            WRITE: begin
                next_state = (words_left == CNT_W'(1)) ? DONE : RECV;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr       <= '0;
            words_left <= '0;
        end else if (start_ok) begin
            addr       <= '0;
            words_left <= bus.word_count;
        end else if (state == WRITE) begin
            addr       <= addr + 64'd4;
            words_left <= words_left - CNT_W'(1);
        end
    end

    assign bus.byte_ready = (state == RECV);
    assign bus.wr_en      = (state == WRITE);
    assign bus.wr_addr    = addr;
    assign bus.wr_data    = word;
    assign bus.busy       = (state == RECV) || (state == WRITE);
    assign bus.done       = (state == DONE);
    assign bus.error      = (state == ERR);
    assign bus.core_hold  = (state != DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader; expected writes come from
// packing the transmitted byte list four bytes at a time.
module tb_imem_loader;
    import imem_pkg::*;

    logic clk;
    logic reset_n;

    imem_loader_if #(.CNT_W(CNT_W)) bus ();

    imem_loader #(.MEM_SIZE(IMEM_SIZE)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int          assertCount = 0;
    int          failCount   = 0;
    int          wrRun       = 0;
    int          maxRun      = 0;
    bit          streamOk;
    logic [7:0]  txBytes[$];
    logic [63:0] obsAddr[$];
    logic [31:0] obsData[$];

    // Record every write strobe and the longest run of consecutive strobe cycles.
    always @(negedge clk) begin
        if (bus.wr_en) begin
            obsAddr.push_back(bus.wr_addr);
            obsData.push_back(bus.wr_data);
            wrRun++;
            if (wrRun > maxRun) maxRun = wrRun;
        end else begin
            wrRun = 0;
        end
    end

    function automatic logic [31:0] expWord(input int i);
        return 32'(txBytes[4*i]) + (32'(txBytes[4*i+1]) << 8)
             + (32'(txBytes[4*i+2]) << 16) + (32'(txBytes[4*i+3]) << 24);
    endfunction

    task automatic clearObs();
        obsAddr.delete();
        obsData.delete();
        maxRun = 0;
    endtask

    task automatic waitIdle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulseStart(input int n);
        bus.start      = 1'b1;
        bus.word_count = CNT_W'(n);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic sendByte(input logic [7:0] b, output bit ok);
        ok             = 1'b0;
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (bus.byte_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
                break;
            end
        end
        bus.byte_valid = 1'b0;
    endtask

    task automatic waitForDone(input int limit, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < limit; c++) begin
            @(negedge clk);
            if (bus.done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        reset_n = 1'b0;
        #12;
        assertCount++;
        if ({bus.byte_ready, bus.wr_en, bus.busy, bus.done, bus.error, bus.core_hold} !== 6'b000001) begin
            failCount++;
            $display("[TB] FAIL reset_flags: got %b expected %b",
                     {bus.byte_ready, bus.wr_en, bus.busy, bus.done, bus.error, bus.core_hold}, 6'b000001);
        end
        assertCount++;
        if (bus.wr_addr !== 64'd0 || bus.wr_data !== 32'd0) begin
            failCount++;
            $display("[TB] FAIL reset_bus: got addr %h data %h expected 0/0", bus.wr_addr, bus.wr_data);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        assertCount++;
        if ({bus.busy, bus.done, bus.error, bus.core_hold} !== 4'b0001) begin
            failCount++;
            $display("[TB] FAIL idle_after_reset: got %b expected %b",
                     {bus.busy, bus.done, bus.error, bus.core_hold}, 4'b0001);
        end
    endtask

    task automatic test_basic();
        bit ok;
        $display("[TB] test_basic");
        clearObs();
        txBytes  = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        streamOk = 1'b1;
        pulseStart(2);
        for (int i = 0; i < 8; i++) begin
            sendByte(txBytes[i], ok);
            streamOk &= ok;
            if (i == 3) begin
                @(negedge clk);
                assertCount++;
                if (bus.wr_en !== 1'b1) begin
                    failCount++;
                    $display("[TB] FAIL basic_latency: wr_en got %b expected 1", bus.wr_en);
                end
            end
        end
        @(posedge clk);
        #1;
        assertCount++;
        if ({bus.done, bus.core_hold, bus.busy} !== 3'b100) begin
            failCount++;
            $display("[TB] FAIL basic_done: got done/hold/busy %b expected 100",
                     {bus.done, bus.core_hold, bus.busy});
        end
        assertCount++;
        if (streamOk !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL basic_stream_timeout: got %b expected 1", streamOk);
        end
        assertCount++;
        if (obsAddr.size() != 2) begin
            failCount++;
            $display("[TB] FAIL basic_write_count: got %0d expected 2", obsAddr.size());
        end else begin
            if (obsAddr[0] !== 64'd0 || obsData[0] !== 32'h12345678) begin
                failCount++;
                $display("[TB] FAIL basic_word0: got %h/%h expected 0/12345678", obsAddr[0], obsData[0]);
            end
            assertCount++;
            if (obsAddr[1] !== 64'd4 || obsData[1] !== 32'hDEADBEEF) begin
                failCount++;
                $display("[TB] FAIL basic_word1: got %h/%h expected 4/deadbeef", obsAddr[1], obsData[1]);
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        $display("[TB] test_backpressure");
        clearObs();
        txBytes.delete();
        for (int i = 0; i < 4; i++) txBytes.push_back(8'($urandom));
        streamOk = 1'b1;
        pulseStart(1);
        for (int i = 0; i < 4; i++) begin
            sendByte(txBytes[i], ok);
            streamOk &= ok;
            if (i == 1) begin
                bus.start      = 1'b1;
                bus.word_count = CNT_W'(5);
                @(posedge clk);
                #1;
                bus.start = 1'b0;
                waitIdle(2);
            end else if (i < 3) begin
                waitIdle(3);
            end
        end
        waitForDone(20, ok);
        streamOk &= ok;
        waitIdle(12);
        assertCount++;
        if (streamOk !== 1'b1 || bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL bp_finish: got ok %b done %b busy %b expected 1/1/0",
                     streamOk, bus.done, bus.busy);
        end
        assertCount++;
        if (obsAddr.size() != 1 || obsAddr[0] !== 64'd0 || obsData[0] !== expWord(0)) begin
            failCount++;
            $display("[TB] FAIL bp_write: got %0d writes, first data %h expected 1 write of %h",
                     obsAddr.size(), (obsData.size() > 0) ? obsData[0] : 32'h0, expWord(0));
        end
        assertCount++;
        if (maxRun != 1) begin
            failCount++;
            $display("[TB] FAIL bp_pulse_width: got %0d expected 1", maxRun);
        end
    endtask

    task automatic test_bounds();
        bit ok;
        int bad;
        $display("[TB] test_bounds");
        clearObs();
        pulseStart(257);
        assertCount++;
        if ({bus.error, bus.core_hold, bus.done, bus.busy} !== 4'b1100) begin
            failCount++;
            $display("[TB] FAIL bound_257: got err/hold/done/busy %b expected 1100",
                     {bus.error, bus.core_hold, bus.done, bus.busy});
        end
        pulseStart(0);
        assertCount++;
        if ({bus.done, bus.error, bus.core_hold, bus.busy} !== 4'b1000) begin
            failCount++;
            $display("[TB] FAIL bound_zero: got done/err/hold/busy %b expected 1000",
                     {bus.done, bus.error, bus.core_hold, bus.busy});
        end
        waitIdle(5);
        assertCount++;
        if (obsAddr.size() != 0) begin
            failCount++;
            $display("[TB] FAIL bound_no_writes: got %0d writes expected 0", obsAddr.size());
        end

        txBytes.delete();
        for (int i = 0; i < 4 * IMEM_WORDS; i++) txBytes.push_back(8'($urandom));
        streamOk = 1'b1;
        pulseStart(IMEM_WORDS);
        for (int i = 0; i < 4 * IMEM_WORDS; i++) begin
            sendByte(txBytes[i], ok);
            streamOk &= ok;
        end
        waitForDone(20, ok);
        streamOk &= ok;
        assertCount++;
        if (streamOk !== 1'b1 || obsAddr.size() != IMEM_WORDS) begin
            failCount++;
            $display("[TB] FAIL bound_full_count: got ok %b writes %0d expected 1/%0d",
                     streamOk, obsAddr.size(), IMEM_WORDS);
        end
        bad = 0;
        for (int i = 0; i < obsAddr.size() && i < IMEM_WORDS; i++) begin
            if (obsAddr[i] !== 64'(4 * i) || obsData[i] !== expWord(i)) bad++;
        end
        assertCount++;
        if (bad != 0) begin
            failCount++;
            $display("[TB] FAIL bound_full_data: got %0d wrong words expected 0", bad);
        end
        assertCount++;
        if (obsAddr.size() == 0 || obsAddr[obsAddr.size()-1] !== 64'd1020) begin
            failCount++;
            $display("[TB] FAIL bound_last_addr: got %h expected 3fc",
                     (obsAddr.size() > 0) ? obsAddr[obsAddr.size()-1] : 64'h0);
        end
    endtask

    task automatic test_reload();
        bit ok;
        $display("[TB] test_reload");
        clearObs();
        txBytes.delete();
        for (int i = 0; i < 4; i++) txBytes.push_back(8'($urandom));
        pulseStart(1);
        assertCount++;
        if ({bus.core_hold, bus.done, bus.busy} !== 3'b101) begin
            failCount++;
            $display("[TB] FAIL reload_flags: got hold/done/busy %b expected 101",
                     {bus.core_hold, bus.done, bus.busy});
        end
        streamOk = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sendByte(txBytes[i], ok);
            streamOk &= ok;
        end
        waitForDone(20, ok);
        streamOk &= ok;
        assertCount++;
        if (streamOk !== 1'b1 || obsAddr.size() != 1 || obsAddr[0] !== 64'd0 || obsData[0] !== expWord(0)) begin
            failCount++;
            $display("[TB] FAIL reload_write: got ok %b writes %0d data %h expected 1/1/%h",
                     streamOk, obsAddr.size(), (obsData.size() > 0) ? obsData[0] : 32'h0, expWord(0));
        end
    endtask

    task automatic test_abort_reload();
        bit ok;
        $display("[TB] test_abort_reload");
        streamOk = 1'b1;
        pulseStart(2);
        for (int i = 0; i < 6; i++) begin
            sendByte(8'($urandom), ok);
            streamOk &= ok;
        end
        #2;
        reset_n = 1'b0;
        #1;
        assertCount++;
        if ({bus.byte_ready, bus.wr_en, bus.busy, bus.done, bus.error, bus.core_hold} !== 6'b000001) begin
            failCount++;
            $display("[TB] FAIL abort_flags: got %b expected %b",
                     {bus.byte_ready, bus.wr_en, bus.busy, bus.done, bus.error, bus.core_hold}, 6'b000001);
        end
        assertCount++;
        if (bus.wr_addr !== 64'd0 || bus.wr_data !== 32'd0) begin
            failCount++;
            $display("[TB] FAIL abort_bus: got addr %h data %h expected 0/0", bus.wr_addr, bus.wr_data);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        clearObs();
        txBytes = '{8'h01, 8'h02, 8'h03, 8'h04};
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'hAA;
        pulseStart(1);
        bus.byte_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sendByte(txBytes[i], ok);
            streamOk &= ok;
        end
        waitForDone(20, ok);
        streamOk &= ok;
        assertCount++;
        if (streamOk !== 1'b1 || obsAddr.size() != 1 || obsAddr[0] !== 64'd0 || obsData[0] !== 32'h04030201) begin
            failCount++;
            $display("[TB] FAIL abort_reload_write: got ok %b writes %0d data %h expected 1/1/04030201",
                     streamOk, obsAddr.size(), (obsData.size() > 0) ? obsData[0] : 32'h0);
        end
    endtask

    task automatic test_random();
        bit ok;
        int n;
        int bad;
        $display("[TB] test_random");
        for (int iter = 0; iter < 6; iter++) begin
            clearObs();
            n = $urandom_range(1, 6);
            txBytes.delete();
            for (int i = 0; i < 4 * n; i++) txBytes.push_back(8'($urandom));
            streamOk = 1'b1;
            pulseStart(n);
            for (int i = 0; i < 4 * n; i++) begin
                sendByte(txBytes[i], ok);
                streamOk &= ok;
                if ($urandom_range(0, 7) == 0) begin
                    bus.start      = 1'b1;
                    bus.word_count = CNT_W'($urandom_range(0, 300));
                    @(posedge clk);
                    #1;
                    bus.start = 1'b0;
                end
                waitIdle($urandom_range(0, 2));
            end
            waitForDone(30, ok);
            streamOk &= ok;
            bad = 0;
            for (int i = 0; i < obsAddr.size() && i < n; i++) begin
                if (obsAddr[i] !== 64'(4 * i) || obsData[i] !== expWord(i)) bad++;
            end
            assertCount++;
            if (streamOk !== 1'b1 || obsAddr.size() != n || bad != 0 || maxRun != 1) begin
                failCount++;
                $display("[TB] FAIL random_load%0d: got ok %b writes %0d bad %0d run %0d expected 1/%0d/0/1",
                         iter, streamOk, obsAddr.size(), bad, maxRun, n);
            end
        end
    endtask

    initial begin
        clk            = 1'b0;
        reset_n        = 1'b0;
        bus.start      = 1'b0;
        bus.word_count = '0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        test_reset();
        test_basic();
        test_backpressure();
        test_bounds();
        test_reload();
        test_abort_reload();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side companion to the instruction memory. It receives a program as a byte stream over a valid/ready handshake and packs each group of four bytes into a little-endian 32-bit word.
- It drives the write port of a writable instruction memory at word-aligned byte addresses, starting from 0.
- It holds the core in reset through `core_hold` until the whole program has been written.

Parameters:
- MEM_SIZE, 1024, instruction memory size in bytes; must be a power of two and greater than 4.
- CNT_W, $clog2(MEM_SIZE/4)+1, width of the word-count field (9 at the default).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a load.
- word_count  in  CNT_W  number of 32-bit words to load; sampled when `start` is accepted.
- byte_valid  in  1  `byte_data` is valid.
- byte_data  in  8  program byte; bytes arrive in increasing address order.
- byte_ready  out  1  loader accepts a byte this cycle.
- wr_en  out  1  instruction memory write strobe.
- wr_addr  out  64  byte address; bits [1:0] are always 0.
- wr_data  out  32  instruction word.
- busy  out  1  load in progress (RECV or WRITE state).
- done  out  1  last load completed successfully.
- error  out  1  last load was rejected.
- core_hold  out  1  keep the CPU in reset.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - State goes to IDLE.
  - `byte_ready`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `busy`=0, `done`=0, `error`=0, `core_hold`=1.
  - Any partial word is discarded.
  - Reset asserted mid-load aborts the load; memory contents already written are left as they are.
- States: IDLE, RECV, WRITE, DONE, ERR. All outputs are registered or decoded from the registered state only.
- IDLE, DONE and ERR on `start`=1:
  - `word_count`=0 → DONE next cycle, no writes.
  - `word_count` > MEM_SIZE/4 → ERR next cycle, no writes.
  - Otherwise: latch `word_count` into `words_left`, set address=0, byte index=0 → RECV. `done` and `error` clear.
- RECV:
  - `byte_ready`=1.
  - A byte is accepted when `byte_valid && byte_ready`.
  - Byte index k (0..3) is written into lanes [8k+7:8k], so the first byte becomes bits [7:0].
  - Accepting byte index 3 → WRITE next cycle.
  - `byte_valid`=0 stalls the loader indefinitely, with no timeout.
- WRITE:
  - Lasts exactly one cycle, with `wr_en`=1, `wr_addr`=current address, `wr_data`=assembled word, and `byte_ready`=0.
  - Next cycle: address += 4, `words_left` -= 1.
  - If `words_left` was 1 → DONE, otherwise → RECV with byte index 0.
- Latency and throughput:
  - `wr_en` rises on the clock edge after the 4th byte is accepted.
  - Best-case throughput is one word per 5 cycles.
- DONE: `done`=1, `core_hold`=0, `busy`=0. The state is held until the next `start`.
- ERR: `error`=1, `core_hold`=1. The state is held until the next `start`.
- `start` during RECV or WRITE is ignored and `word_count` is not re-sampled.
- Address bound: the highest write is at MEM_SIZE-4. The upfront count check guarantees the address never wraps.
- A simultaneous `byte_valid` and `start` while in IDLE: the byte is not accepted, because `byte_ready` is 0 in IDLE.
- `core_hold` returns to 1 on any new accepted `start`.

Decomposition:
- Package `imem_pkg` holds:
  - the `loader_state_t` enum (IDLE, RECV, WRITE, DONE, ERR);
  - the `IMEM_SIZE`=1024 constant, shared with the instruction memory;
  - the `IMEM_WORDS` constant;
  - the `CNT_W` localparam helper.
- Sub-module `byte_packer`:
  - 2-bit lane index plus a 32-bit assembly register;
  - inputs: `accept`, `clear`, `byte_data`;
  - outputs: `word`, `last_byte` (index==3 and `accept`).
- The FSM, address counter and `words_left` counter stay in `imem_loader`.

Test Plan:
- Reset → check `byte_ready`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `busy`=0, `done`=0, `error`=0, `core_hold`=1; pulse reset_n during RECV and check the same values asynchronously, before the next edge.
- Basic load: `start`, `word_count`=2, bytes 78,56,34,12,EF,BE,AD,DE with `byte_valid` held high → exactly two `wr_en` pulses: addr 0 / 0x12345678, then addr 4 / 0xDEADBEEF; `done`=1 and `core_hold`=0 on the cycle after the second write.
- Backpressure and stray `start`: `word_count`=1 with `byte_valid` gaps of 3 cycles between bytes and a `start` pulse mid-stream → a single write of the correct word, `word_count` not re-sampled, `wr_en` pulse width exactly 1.
- Bounds: `word_count`=0 → `done`=1 one cycle after `start`, no writes; `word_count`=257 → `error`=1, `core_hold`=1, no writes; `word_count`=256 → 256 writes, the last at `wr_addr`=1020.
- Abort and reload: after 2 bytes, drop reset_n for 1 cycle, then `start` with `word_count`=1 and bytes 01,02,03,04 → write at addr 0 with data 0x04030201; the stale bytes do not appear.
- Reload after DONE: a second `start` with `word_count`=1 → `core_hold` returns to 1, `done` clears, and the write goes to addr 0.
